// File: rtl/count_en_gen.sv
// Programmable-rate enable pulse generator with start/stop control and optional fixed-length bursts.
// Optional feature: define COUNT_EN_GEN_PAUSE_EN to add a pause input that freezes a run in place.
module count_en_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
`ifdef COUNT_EN_GEN_PAUSE_EN
  input  logic                   pause,
`endif
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   count_en,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] pulse_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
  logic [BURST_WIDTH-1:0] burst_lat_q, burst_lat_d;
  logic [BURST_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                   count_en_q, count_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   paused;
  logic                   pulse_due;
  logic                   burst_end;

`ifdef COUNT_EN_GEN_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign pulse_due = (presc_q == div_lat_q);
  assign burst_end = (burst_lat_q != '0) && (pulse_cnt_q + 1'b1 == burst_lat_q);

  // State register and all registered outputs; reset wins over every other input.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      div_lat_q   <= '0;
      burst_lat_q <= '0;
      pulse_cnt_q <= '0;
      count_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      div_lat_q   <= div_lat_d;
      burst_lat_q <= burst_lat_d;
      pulse_cnt_q <= pulse_cnt_d;
      count_en_q  <= count_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; stop outranks pause, which outranks a due pulse.
  // NOTE: a default assignment first in every always_comb keeps it free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop)                                state_d = IDLE;
        else if (!paused && pulse_due && burst_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; count_en and done default low so they are single-cycle pulses.
  always_comb begin
    presc_d     = presc_q;
    div_lat_d   = div_lat_q;
    burst_lat_d = burst_lat_q;
    pulse_cnt_d = pulse_cnt_q;
    count_en_d  = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          div_lat_d   = div;
          burst_lat_d = burst_len;
          presc_d     = '0;
          pulse_cnt_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          presc_d = '0;
        end else if (!paused) begin
          if (pulse_due) begin
            count_en_d  = 1'b1;
            presc_d     = '0;
            pulse_cnt_d = pulse_cnt_q + 1'b1;
            done_d      = burst_end;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      default: presc_d = '0;
    endcase
    busy_d = (state_d == RUN);
  end

  assign count_en  = count_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_count_en_gen.sv
// Self-checking bench for count_en_gen: directed scenarios plus random traffic against a cycle-count model.
// Builds with or without COUNT_EN_GEN_PAUSE_EN; pause stimulus is only driven when the port exists.
module tb_count_en_gen;

  localparam int DW = 16;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset, start, stop, pause;
  logic [DW-1:0] div;
  logic [BW-1:0] burst_len;
  logic          count_en, busy, done;
  logic [BW-1:0] pulse_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: a run is a count of un-paused RUN edges; a pulse falls on every (div+1)-th one.
  bit            m_run, m_en, m_busy, m_done;
  int            m_div, m_blen, m_elapsed;
  logic [BW-1:0] m_cnt;

  always #5 clk = ~clk;

  count_en_gen #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
`ifdef COUNT_EN_GEN_PAUSE_EN
    .pause     (pause),
`endif
    .div       (div),
    .burst_len (burst_len),
    .count_en  (count_en),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_run = 0; m_en = 0; m_busy = 0; m_done = 0;
      m_cnt = '0; m_div = 0; m_blen = 0; m_elapsed = 0;
    end else if (!m_run) begin
      m_en = 0; m_done = 0;
      if (start && !stop) begin
        m_run = 1; m_busy = 1; m_div = int'(div); m_blen = int'(burst_len);
        m_elapsed = 0; m_cnt = '0;
      end
    end else if (stop) begin
      m_run = 0; m_en = 0; m_busy = 0; m_done = 0;
    end else if (pause) begin
      m_en = 0;
    end else begin
      m_elapsed++;
      m_en = (m_elapsed % (m_div + 1)) == 0;
      if (m_en) begin
        m_cnt++;
        if (m_blen != 0 && int'(m_cnt) == m_blen) begin
          m_done = 1; m_busy = 0; m_run = 0;
        end
      end
    end
  endtask

  // One clock edge with the currently driven inputs, then compare all outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("count_en",  32'(count_en),  32'(m_en));
    check("busy",      32'(busy),      32'(m_busy));
    check("done",      32'(done),      32'(m_done));
    check("pulse_cnt", 32'(pulse_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input int d, input int b);
    reset = r; start = s; stop = p; div = DW'(d); burst_len = BW'(b);
  endtask

  initial begin
    pause = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 3, 4);

    // Reset held with start high: nothing starts.
    tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);

    // div=3, burst=4: pulses after k+4, k+8, k+12, k+16; done on the 4th.
    drive(1'b1, 1'b1, 1'b0, 3, 4); tick();
    start = 1'b0;
    repeat (16) tick();
    check("burst_done_pulse", 32'(done), 32'd1);
    repeat (3) tick();
    check("burst_cnt_hold", 32'(pulse_cnt), 32'd4);

    // div=0 continuous, stop after 10 pulses.
    drive(1'b1, 1'b1, 1'b0, 0, 0); tick();
    start = 1'b0;
    repeat (10) tick();
    check("cont_cnt", 32'(pulse_cnt), 32'd10);
    stop = 1'b1; tick();
    stop = 1'b0; tick();
    check("cont_stopped_en", 32'(count_en), 32'd0);

    // div=2, burst=5, stop on the edge where the 2nd pulse is due.
    drive(1'b1, 1'b1, 1'b0, 2, 5); tick();
    start = 1'b0;
    repeat (5) tick();
    stop = 1'b1; tick();
    stop = 1'b0;
    check("stop_suppress_cnt", 32'(pulse_cnt), 32'd1);
    check("stop_suppress_en",  32'(count_en),  32'd0);
    tick();

    // div=1 continuous, reset mid-run with start high; nothing resumes after.
    drive(1'b1, 1'b1, 1'b0, 1, 0); tick();
    start = 1'b0;
    repeat (5) tick();
    drive(1'b0, 1'b1, 1'b0, 1, 0); tick();
    check("reset_mid_cnt", 32'(pulse_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1, 0);
    repeat (4) tick();

    // start+stop together in IDLE, then start during RUN with a new div.
    drive(1'b1, 1'b1, 1'b1, 2, 0); tick();
    check("start_stop_idle", 32'(busy), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2, 0); tick();
    div = DW'(7);
    repeat (9) tick();
    check("restart_ignored_cnt", 32'(pulse_cnt), 32'd3);
    drive(1'b1, 1'b0, 1'b1, 7, 0); tick();
    stop = 1'b0;

`ifdef COUNT_EN_GEN_PAUSE_EN
    // Pause for 5 cycles mid-period: the next pulse slips by exactly 5 cycles.
    drive(1'b1, 1'b1, 1'b0, 5, 0); tick();
    start = 1'b0;
    repeat (3) tick();
    pause = 1'b1; repeat (5) tick();
    pause = 1'b0; repeat (2) tick();
    check("pause_no_early", 32'(count_en), 32'd0);
    tick();
    check("pause_delayed_pulse", 32'(count_en), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(63) != 0);
      start     = ($urandom_range(7) == 0);
      stop      = ($urandom_range(31) == 0);
`ifdef COUNT_EN_GEN_PAUSE_EN
      pause     = ($urandom_range(7) == 0);
`endif
      div       = DW'($urandom_range(5));
      burst_len = BW'($urandom_range(6));
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule

// File: doc/count_en_gen.md
Name: count_en_gen

Overview:
Upstream enable source for the 32-bit event counter: drives its count_en input with single-cycle pulses at a programmable rate.
Start/stop control plus optional fixed-length bursts, so the counter advances by an exact, known amount per run.
Outputs are registered, so count_en can connect directly to the counter's count_en input.

Parameters:
DIV_WIDTH, 16, width of the prescaler divide value and its internal counter.
BURST_WIDTH, 16, width of the burst length and the issued-pulse counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset: sampled on rising clk edge, resets when 0.
start  input  1  level sampled each edge; begins a run when in IDLE.
stop  input  1  level sampled each edge; aborts a run.
div  input  DIV_WIDTH  pulse period minus 1; latched at start.
burst_len  input  BURST_WIDTH  pulses per run; 0 = continuous; latched at start.
count_en  output  1  one-cycle enable pulse to the downstream counter.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse on burst completion.
pulse_cnt  output  BURST_WIDTH  pulses issued since last start.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; count_en=0, busy=0, done=0, pulse_cnt=0; prescaler=0; latched div/burst_len=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN. Two-state FSM, all outputs registered.
- IDLE, start=1 and stop=0 at edge k:
  - latch div and burst_len; prescaler<=0; pulse_cnt<=0; busy<=1; go RUN.
  - start=1 together with stop=1: stay IDLE; nothing changes.
- RUN, each edge with stop=0:
  - if prescaler==div_lat: count_en<=1, prescaler<=0, pulse_cnt<=pulse_cnt+1.
  - else: count_en<=0, prescaler<=prescaler+1.
- Timing: first count_en is high in the cycle after edge k+div+1; period is div+1 cycles; duty is 1 cycle.
- div=0: count_en high every cycle from edge k+1 onward.
- Burst end (burst_len_lat!=0 and the issuing pulse makes pulse_cnt==burst_len_lat):
  - same edge: count_en<=1, done<=1, busy<=0, go IDLE.
  - next edge: count_en<=0, done<=0.
- Continuous mode (burst_len_lat==0): runs until stop; pulse_cnt wraps from all-ones to 0 silently.
- stop=1 in RUN:
  - go IDLE; count_en<=0, busy<=0, done stays 0.
  - pulse_cnt holds its value; prescaler<=0.
  - stop has priority over a due pulse; that pulse is suppressed.
- start=1 while RUN: ignored, no restart. div/burst_len changes during RUN have no effect.
- done is high in exactly one cycle per completed burst. It never asserts on stop or reset.
- pulse_cnt holds after a run ends and clears only on the next accepted start or on reset.

Optional Feature:
COUNT_EN_GEN_PAUSE_EN defined:
- adds input port pause (1 bit).
- RUN with pause=1 and stop=0: prescaler and pulse_cnt hold; count_en<=0; busy stays 1.
- on release, counting resumes from the held prescaler value.
- stop beats pause; reset beats all.
Not defined: no pause port; behaviour exactly as above.

Test Plan:
1. reset=0 for 2 edges with start=1 -> count_en=0, busy=0, done=0, pulse_cnt=0 throughout; no run begins.
2. div=3, burst_len=4, start pulse at edge k -> count_en high after edges k+4, k+8, k+12, k+16. done and busy falling coincide with the 4th pulse; pulse_cnt=4 and holds.
3. div=0, burst_len=0, start, then stop after 10 cycles -> count_en high every cycle (10 pulses), pulse_cnt=10; count_en=0 and busy=0 after the stop edge; done never asserts.
4. div=2, burst_len=5, stop asserted on the edge where the 2nd pulse is due -> pulse suppressed, pulse_cnt=1, IDLE, done=0.
5. div=1, burst_len=0, reset=0 mid-run with start=1 simultaneously -> all outputs 0 after that edge; no run resumes until a new start with reset=1.
6. start+stop together in IDLE -> stays IDLE. Start during RUN with new div -> period unchanged. (With COUNT_EN_GEN_PAUSE_EN: pause for 5 cycles mid-period -> next pulse delayed exactly 5 cycles.)
